// File: rtl/abro_arbiter.sv
// abro_arbiter: NUM_CH independent ABRO channels feeding a registered round-robin completion slot.
// Define ABRO_ARB_COUNT_EN to build the saturating accepted-completion counter on O_count.
module abro_arbiter #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_CH-1:0]     A,
    input  logic [NUM_CH-1:0]     B,
    input  logic [NUM_CH-1:0]     R,
    input  logic                  O_ready,
    output logic                  O_valid,
    output logic [CH_W-1:0]       O_ch,
    output logic [3*NUM_CH-1:0]   State,
    output logic [15:0]           O_count
);
    typedef enum logic [2:0] {
        WAIT_AB = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_A  = 3'd2,
        PEND    = 3'd3,
        GRANT   = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t            st [NUM_CH];
    logic [CH_W-1:0]   last, win;
    logic [NUM_CH-1:0] elig;
    logic              hs, withdraw, load, found;

    // A restart on the offered channel without acceptance frees the slot for a replacement.
    always_comb begin
        hs       = O_valid & O_ready;
        withdraw = O_valid & ~O_ready & R[O_ch];
        elig     = '0;
        win      = last;
        found    = 1'b0;
        for (int i = 0; i < NUM_CH; i++)
            elig[i] = (st[i] == PEND) && !R[i];
        for (int k = 1; k <= NUM_CH; k++)
            if (!found && elig[(int'(last) + k) % NUM_CH]) begin
                found = 1'b1;
                win   = CH_W'((int'(last) + k) % NUM_CH);
            end
        load = found & (~O_valid | hs | withdraw);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++)
                st[i] <= WAIT_AB;
            O_valid <= 1'b0;
            O_ch    <= '0;
            last    <= CH_W'(NUM_CH - 1);
        end else begin
            for (int i = 0; i < NUM_CH; i++)
                if (R[i])
                    st[i] <= WAIT_AB;
                else
                    case (st[i])
                        WAIT_AB: st[i] <= (A[i] && B[i]) ? PEND : A[i] ? WAIT_B : B[i] ? WAIT_A : WAIT_AB;
                        WAIT_B:  st[i] <= B[i] ? PEND : WAIT_B;
                        WAIT_A:  st[i] <= A[i] ? PEND : WAIT_A;
                        PEND:    st[i] <= (load && win == CH_W'(i)) ? GRANT : PEND;
                        GRANT:   st[i] <= hs ? DONE : GRANT;
                        DONE:    st[i] <= DONE;
                        default: st[i] <= WAIT_AB;
                    endcase
            if (load) begin
                O_valid <= 1'b1;
                O_ch    <= win;
                last    <= win;
            end else if (hs || withdraw) begin
                O_valid <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_state
        assign State[3*g +: 3] = st[g];
    end

`ifdef ABRO_ARB_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset)
            O_count <= '0;
        else if (hs && O_count != 16'hFFFF)
            O_count <= O_count + 16'd1;
    end
`else
    assign O_count = '0;
`endif
endmodule

// File: tb/tb_abro_arbiter.sv
// tb_abro_arbiter: directed vectors with hand-computed expectations for abro_arbiter (NUM_CH=4).
module tb_abro_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  A = '0, B = '0, R = '0;
    logic        O_ready = 1'b0;
    logic        O_valid;
    logic [1:0]  O_ch;
    logic [11:0] State;
    logic [15:0] O_count;
    int          n_cmp = 0, n_bad = 0;
    int          ecnt = 0;

`ifdef ABRO_ARB_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    abro_arbiter #(.NUM_CH(4), .CH_W(2)) dut (
        .clk(clk), .reset(reset), .A(A), .B(B), .R(R), .O_ready(O_ready),
        .O_valid(O_valid), .O_ch(O_ch), .State(State), .O_count(O_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; A = '0; B = '0; R = '0;
        tick();
        reset = 1'b0;
        ecnt = 0;
    endtask

    task automatic check_cnt(input string tag);
        check(tag, 32'(O_count), CNT_EN ? 32'(ecnt) : 32'd0);
    endtask

    initial begin
        tick();
        do_reset();
        check("rst_valid", 32'(O_valid), 0);
        check("rst_ch", 32'(O_ch), 0);
        check("rst_state", 32'(State), 0);
        check_cnt("rst_cnt");

        // Single channel: A, gap, B
        O_ready = 1'b1;
        A = 4'b0001; tick(); A = '0;
        check("s_waitb", 32'(State[2:0]), 1);
        tick();
        B = 4'b0001; tick(); B = '0;
        check("s_pend", 32'(State[2:0]), 3);
        check("s_novalid", 32'(O_valid), 0);
        tick();
        check("s_offer", {30'd0, O_valid, 1'b0} | 32'(O_ch), 2);
        check("s_grant", 32'(State[2:0]), 4);
        tick(); ecnt++;
        check("s_drop", 32'(O_valid), 0);
        check("s_done", 32'(State[2:0]), 5);
        check_cnt("s_cnt");

        // All four at once, back-to-back from channel 0
        do_reset();
        O_ready = 1'b1;
        A = 4'hF; B = 4'hF; tick(); A = '0; B = '0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("rr_%0d", k), {29'd0, O_valid, O_ch}, {29'd0, 1'b1, 2'(k)});
        end
        tick(); ecnt = 4;
        check("rr_end", 32'(O_valid), 0);
        check("rr_state", 32'(State), 32'hB6D);
        check_cnt("rr_cnt");

        // Backpressure holds the offer
        do_reset();
        O_ready = 1'b0;
        A = 4'b0100; B = 4'b0100; tick(); A = '0; B = '0;
        tick();
        for (int k = 0; k < 10; k++) begin
            check("bp_hold", {29'd0, O_valid, O_ch}, 32'b110);
            tick();
        end
        O_ready = 1'b1; tick(); O_ready = 1'b0; ecnt++;
        check("bp_xfer", 32'(O_valid), 0);
        check("bp_done", 32'(State[8:6]), 5);
        tick();
        check("bp_once", 32'(O_valid), 0);
        check_cnt("bp_cnt");

        // Withdrawal by restart of the granted channel
        do_reset();
        O_ready = 1'b0;
        A = 4'b1100; B = 4'b1100; tick(); A = '0; B = '0;
        tick();
        check("wd_first", {29'd0, O_valid, O_ch}, 32'b110);
        check("wd_pend3", 32'(State[11:9]), 3);
        R = 4'b0100; tick(); R = '0;
        check("wd_repl", {29'd0, O_valid, O_ch}, 32'b111);
        check("wd_st2", 32'(State[8:6]), 0);
        check("wd_st3", 32'(State[11:9]), 4);
        check_cnt("wd_nocnt");
        O_ready = 1'b1; tick(); ecnt++;
        check("wd_acc", 32'(State[11:9]), 5);
        check_cnt("wd_cnt");

        // DONE ignores A/B until restarted
        do_reset();
        O_ready = 1'b1;
        A = 4'b0010; B = 4'b0010; tick(); A = '0; B = '0;
        tick(); tick(); ecnt++;
        check("dn_done", 32'(State[5:3]), 5);
        A = 4'b0010; B = 4'b0010; tick(); A = '0; B = '0;
        check("dn_ignore", 32'(State[5:3]), 5);
        tick();
        check("dn_novalid", 32'(O_valid), 0);
        R = 4'b0010; tick(); R = '0;
        check("dn_restart", 32'(State[5:3]), 0);
        A = 4'b0010; B = 4'b0010; tick(); A = '0; B = '0;
        tick();
        check("dn_reoffer", {29'd0, O_valid, O_ch}, 32'b101);
        // Restart coinciding with acceptance still counts
        R = 4'b0010; tick(); R = '0; ecnt++;
        check("rh_state", 32'(State[5:3]), 0);
        check("rh_valid", 32'(O_valid), 0);
        check_cnt("rh_cnt");

        // Three handshakes, then reset mid-handshake
        do_reset();
        O_ready = 1'b1;
        A = 4'b0111; B = 4'b0111; tick(); A = '0; B = '0;
        tick(); tick(); tick(); tick(); ecnt = 3;
        check_cnt("c3_cnt");
        A = 4'b1000; B = 4'b1000; tick(); A = '0; B = '0;
        tick();
        check("mr_offer", {29'd0, O_valid, O_ch}, 32'b111);
        reset = 1'b1; tick(); reset = 1'b0; ecnt = 0;
        check("mr_valid", 32'(O_valid), 0);
        check("mr_ch", 32'(O_ch), 0);
        check("mr_state", 32'(State), 0);
        check_cnt("mr_cnt");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
